// File: rtl/regbank_pkg.sv
// Shared defaults and types for the register bank.
package regbank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_REGS_DEF = 1 << ADDR_W_DEF;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regbank_read_mux.sv
// NUM_REGS:1 read-port multiplexer; addresses beyond NUM_REGS read as zero.
module regbank_read_mux
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]               sel_i,
    output logic [DATA_W-1:0]               data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_i == ADDR_W'(i)) data_o = regs_i[i];
        end
    end

endmodule

// File: rtl/regbank.sv
// Two-read / one-write register bank with synchronous clear and no write bypass.
module regbank
    import regbank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] dr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (write && (dr == ADDR_W'(i))) regs_d[i] = wrData;
        end
    end

    // Reset wins over a same-edge write by simply ignoring regs_d.
    always_ff @(posedge clk) begin
        if (reset) regs_q <= '0;
        else       regs_q <= regs_d;
    end

    // Reads come straight from the stored array, so a same-cycle write shows only after the edge.
    regbank_read_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rd1 (
        .regs_i(regs_q),
        .sel_i (sr1),
        .data_o(rdData1)
    );

    regbank_read_mux #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) u_rd2 (
        .regs_i(regs_q),
        .sel_i (sr2),
        .data_o(rdData2)
    );

endmodule

// File: tb/tb_regbank.sv
// Self-checking bench for regbank: directed scenarios plus random traffic against an array model.
module tb_regbank;

    logic        clk = 1'b0;
    logic        reset, write;
    logic [4:0]  dr, sr1, sr2;
    logic [31:0] wrData, rdData1, rdData2;

    logic [31:0] mdl [32];
    int n_chk = 0;
    int n_err = 0;

    regbank dut (
        .clk    (clk),
        .reset  (reset),
        .write  (write),
        .dr     (dr),
        .wrData (wrData),
        .sr1    (sr1),
        .sr2    (sr2),
        .rdData1(rdData1),
        .rdData2(rdData2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; the model follows the register-file rules on the inputs present at the edge.
    task automatic step();
        logic [31:0] nxt [32];
        for (int i = 0; i < 32; i++) nxt[i] = reset ? 32'd0 : mdl[i];
        if (!reset && write) nxt[dr] = wrData;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) mdl[i] = nxt[i];
    endtask

    task automatic rd(input int a1, input int a2, input string tag);
        sr1 = 5'(a1);
        sr2 = 5'(a2);
        #1;
        chk({tag, "_p1"}, rdData1, mdl[a1]);
        chk({tag, "_p2"}, rdData2, mdl[a2]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'hx;
        reset = 1'b1; write = 1'b1; dr = 5'd9; wrData = 32'h1234_5678;
        sr1 = '0; sr2 = '0;
        step();
        reset = 1'b0; write = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(k, 31 - k, "reset_state");
            chk("reset_const", rdData1, 32'd0);
        end

        // Fill then read back pairs
        write = 1'b1;
        for (int k = 0; k < 32; k++) begin
            dr = 5'(k); wrData = 32'(10 * k);
            step();
        end
        write = 1'b0;
        for (int k = 0; k < 32; k += 2) begin
            rd(k, k + 1, "fill");
            chk("fill_abs1", rdData1, 32'(10 * k));
            chk("fill_abs2", rdData2, 32'(10 * (k + 1)));
        end

        // Write disabled over several edges
        write = 1'b0; dr = 5'd5; wrData = 32'hDEAD_BEEF;
        repeat (4) step();
        rd(5, 4, "wr_dis");
        chk("wr_dis_abs", rdData1, 32'd50);

        // Read during write: old value before the edge, new after
        sr1 = 5'd7; dr = 5'd7; wrData = 32'd123; write = 1'b1;
        #1;
        chk("rdw_before", rdData1, 32'd70);
        step();
        write = 1'b0;
        chk("rdw_after", rdData1, 32'd123);

        // Reset clear
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(k, k, "rst_clear");
            chk("rst_clear_abs", rdData2, 32'd0);
        end

        // Reset/write collision
        write = 1'b1; dr = 5'd3; wrData = 32'd33;
        step();
        rd(3, 3, "pre_coll");
        chk("pre_coll_abs", rdData1, 32'd33);
        reset = 1'b1; wrData = 32'd99;
        step();
        reset = 1'b0; write = 1'b0;
        rd(3, 2, "collision");
        chk("collision_abs", rdData1, 32'd0);

        // Register 0 is writable; same-address dual read
        write = 1'b1; dr = 5'd0; wrData = 32'hFFFF_FFFF;
        step();
        write = 1'b0;
        rd(0, 0, "reg0");
        chk("reg0_abs1", rdData1, 32'hFFFF_FFFF);
        chk("reg0_abs2", rdData2, 32'hFFFF_FFFF);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 39) == 0);
            write  = $urandom_range(0, 3) != 0;
            dr     = 5'($urandom_range(0, 31));
            wrData = $urandom;
            rd($urandom_range(0, 31), $urandom_range(0, 31), "rand");
            step();
        end
        reset = 1'b0; write = 1'b0;
        for (int k = 0; k < 32; k++) rd(k, 31 - k, "final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regbank.md
REGBANK -- requirements
Module: regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 32 (2**ADDR_W), meaning number of registers.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port write  input  1  write enable for the write port.
REQ-007 SHALL have port dr  input  ADDR_W  destination register address for writes.
REQ-008 SHALL have port wrData  input  DATA_W  write data.
REQ-009 SHALL have port sr1  input  ADDR_W  read port 1 source address.
REQ-010 SHALL have port sr2  input  ADDR_W  read port 2 source address.
REQ-011 SHALL have port rdData1  output  DATA_W  contents of register sr1.
REQ-012 SHALL have port rdData2  output  DATA_W  contents of register sr2.
REQ-013 SHALL use one clock; reset is synchronous and active-high, sampled only on rising clk.

Function
REQ-014 SHALL hold NUM_REGS registers of DATA_W bits each; register 0 is an ordinary writable register (not hardwired to zero).
REQ-015 SHALL, on rising clk with reset=0 and write=1, load wrData into register dr; all other registers hold.
REQ-016 SHALL, on rising clk with write=0 and reset=0, leave every register unchanged.
REQ-017 SHALL drive rdData1 = reg[sr1] and rdData2 = reg[sr2] combinationally (zero-cycle read latency, no clock needed).
REQ-018 SHALL allow sr1 == sr2; both outputs then show the same register.
REQ-019 SHALL, when a read address equals dr during a write cycle, show the old value until the rising edge and the new value immediately after it (no write-to-read bypass).
REQ-020 SHALL treat X/unknown read addresses as don't-care; outputs then are unspecified, no state corruption.
REQ-021 SHALL have no handshake; one write per cycle, two reads always available.

Reset
REQ-022 SHALL, on rising clk with reset=1, clear all NUM_REGS registers to 0, regardless of write.
REQ-023 SHALL give reset priority over a simultaneous write; the write is discarded.
REQ-024 SHALL make rdData1/rdData2 read 0 for every address after reset (outputs follow register contents, no separate output reset).
REQ-025 SHALL leave register contents undefined before the first reset edge; benches apply reset before reading.

Structure
REQ-026 SHALL place DATA_W, ADDR_W, NUM_REGS defaults and a reg_data_t (DATA_W-bit) typedef in shared package regbank_pkg.
REQ-027 SHALL implement the storage array and write logic in regbank; the two read ports are instances of one sub-module regbank_read_mux (NUM_REGS:1 DATA_W-bit mux).
REQ-028 SHALL be fully synthesizable, no latches, no initial blocks in RTL.

Verification
REQ-029 SHALL cover fill/readback: reset, then for k=0..31 write dr=k, wrData=10*k for one cycle each; read sr1=k, sr2=k+1 for even k -> rdData1=10*k, rdData2=10*(k+1) (e.g. reg[30]=300, reg[31]=310).
REQ-030 SHALL cover reset clear: after fill, assert reset one cycle -> all 32 registers read 0 on both ports.
REQ-031 SHALL cover write disable: write=0, dr=5, wrData=32'hDEADBEEF over several edges -> reg[5] unchanged (50).
REQ-032 SHALL cover read-during-write: sr1=dr=7, reg[7]=70, write wrData=123 -> rdData1=70 before edge, 123 after edge.
REQ-033 SHALL cover reset/write collision: reset=1, write=1, dr=3, wrData=99 same edge -> reg[3]=0.
REQ-034 SHALL cover same-address dual read and register 0: write reg[0]=32'hFFFFFFFF, sr1=sr2=0 -> both outputs 32'hFFFFFFFF.
